// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_pkg
// Description : Shared widths, state encoding and helpers for the MAC PE.
// Revision    : 1.0 - initial release
// ============================================================================
package pe_pkg;

    localparam int c_IFMAP_W  = 8;
    localparam int c_WEIGHT_W = 8;
    localparam int c_ACC_W    = 32;
    localparam int c_CNT_W    = 16;
    localparam int c_IFMAP_ZP = 128;

    localparam int c_STATE_W = 2;
    typedef logic [c_STATE_W-1:0] pe_state_t;

    localparam pe_state_t c_ST_IDLE = 2'd0;
    localparam pe_state_t c_ST_ACC  = 2'd1;
    localparam pe_state_t c_ST_DONE = 2'd2;

    // One bit for the zero-extended ifmap sign, one for the ZP subtraction carry.
    function automatic int prod_width(input int ifmap_w, input int weight_w);
        return ifmap_w + weight_w + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_zp_mult.sv
`default_nettype none
// ============================================================================
// Module      : pe_zp_mult
// Description : Combinational (ifmap - zero point) x signed weight multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_zp_mult
    import pe_pkg::*;
#(
    parameter int IFMAP_W  = c_IFMAP_W,
    parameter int WEIGHT_W = c_WEIGHT_W,
    parameter int IFMAP_ZP = c_IFMAP_ZP,
    parameter int PROD_W   = prod_width(IFMAP_W, WEIGHT_W)
) (
    input  logic                       i_clk_unused_n,
    input  logic        [IFMAP_W-1:0]  i_ifmap,
    input  logic signed [WEIGHT_W-1:0] i_weight,
    output logic signed [PROD_W-1:0]   o_prod
);

    logic signed [PROD_W-1:0] w_ifmap_ext;
    logic signed [PROD_W-1:0] w_zp;
    logic signed [PROD_W-1:0] w_ifmap_adj;
    logic signed [PROD_W-1:0] w_weight_ext;
    logic                     w_unused;

    assign w_unused     = i_clk_unused_n;
    assign w_ifmap_ext  = PROD_W'({1'b0, i_ifmap});
    assign w_zp         = PROD_W'(IFMAP_ZP);
    assign w_ifmap_adj  = w_ifmap_ext - w_zp;
    assign w_weight_ext = {{(PROD_W-WEIGHT_W){i_weight[WEIGHT_W-1]}}, i_weight};

    // Both operands fit well inside PROD_W, so the truncated product is exact.
    assign o_prod = w_ifmap_adj * w_weight_ext;

endmodule
`default_nettype wire

// File: rtl/pe_mac_acc.sv
`default_nettype none
// ============================================================================
// Module      : pe_mac_acc
// Description : Multi-cycle MAC processing element with bias, run-length
//               counter, valid/ready streaming and optional output ReLU.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_mac_acc
    import pe_pkg::*;
#(
    parameter int IFMAP_W  = c_IFMAP_W,
    parameter int WEIGHT_W = c_WEIGHT_W,
    parameter int ACC_W    = c_ACC_W,
    parameter int CNT_W    = c_CNT_W,
    parameter int IFMAP_ZP = c_IFMAP_ZP
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic        [CNT_W-1:0]    len,
    input  logic signed [ACC_W-1:0]    bias,
    input  logic                       relu_en,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic        [IFMAP_W-1:0]  ifmap,
    input  logic signed [WEIGHT_W-1:0] weight,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [ACC_W-1:0]    opsum,
    output logic                       busy
);

    localparam int c_PROD_W = prod_width(IFMAP_W, WEIGHT_W);

    pe_state_t                r_state;
    logic signed [ACC_W-1:0]  r_acc;
    logic        [CNT_W-1:0]  r_cnt;
    logic                     r_relu;

    logic signed [c_PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic                       w_beat;
    logic                       w_clamp;

    pe_zp_mult #(
        .IFMAP_W  (IFMAP_W),
        .WEIGHT_W (WEIGHT_W),
        .IFMAP_ZP (IFMAP_ZP),
        .PROD_W   (c_PROD_W)
    ) u_mult (
        .i_clk_unused_n (1'b0),
        .i_ifmap        (ifmap),
        .i_weight       (weight),
        .o_prod         (w_prod)
    );

    // Narrow accumulators simply keep the low bits; the sum wraps either way.
    if (ACC_W > c_PROD_W) begin : g_sext
        assign w_prod_ext = {{(ACC_W-c_PROD_W){w_prod[c_PROD_W-1]}}, w_prod};
    end else if (ACC_W == c_PROD_W) begin : g_same
        assign w_prod_ext = w_prod;
    end else begin : g_trunc
        assign w_prod_ext = ACC_W'(w_prod);
    end

    assign in_ready  = (r_state == c_ST_ACC);
    assign out_valid = (r_state == c_ST_DONE);
    assign busy      = (r_state == c_ST_ACC) || (r_state == c_ST_DONE);
    assign w_beat    = in_valid && in_ready;
    assign w_clamp   = r_relu && r_acc[ACC_W-1];
    assign opsum     = (out_valid && !w_clamp) ? r_acc : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_relu  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_acc   <= bias;
                        r_cnt   <= len;
                        r_relu  <= relu_en;
                        r_state <= (len == '0) ? c_ST_DONE : c_ST_ACC;
                    end
                end
                c_ST_ACC: begin
                    if (w_beat) begin
                        r_acc <= r_acc + w_prod_ext;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= c_ST_DONE;
                        end
                    end
                end
                c_ST_DONE: begin
                    // A start seen here is dropped: the handshake cycle is a bubble.
                    if (out_ready) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pe_mac_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_mac_acc
// Description : Directed self-checking bench for pe_mac_acc (32-bit and 16-bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_mac_acc;

    logic               clk;
    logic               rst;
    logic               start;
    logic [15:0]        len;
    logic signed [31:0] bias;
    logic               relu_en;
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         ifmap;
    logic signed [7:0]  weight;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] opsum;
    logic               busy;

    logic               in_ready16;
    logic               out_valid16;
    logic signed [15:0] opsum16;
    logic               busy16;

    int vectors;
    int miscompares;

    logic [7:0]        v_if [8];
    logic signed [7:0] v_wt [8];

    pe_mac_acc u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .bias      (bias),
        .relu_en   (relu_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ifmap     (ifmap),
        .weight    (weight),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .opsum     (opsum),
        .busy      (busy)
    );

    pe_mac_acc #(.ACC_W(16)) u_dut16 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .bias      (bias[15:0]),
        .relu_en   (relu_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready16),
        .ifmap     (ifmap),
        .weight    (weight),
        .out_valid (out_valid16),
        .out_ready (out_ready),
        .opsum     (opsum16),
        .busy      (busy16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts a run on the next negedge, feeds n beats from v_if/v_wt without
    // gaps, and returns the opsum and the cycle (start = 0) out_valid rose.
    task automatic run_job(input int n, input logic signed [31:0] b, input logic r,
                           output logic signed [31:0] res, output int lat);
        int k;
        int guard;
        logic fired;
        @(negedge clk);
        start = 1'b1; len = 16'(n); bias = b; relu_en = r;
        @(negedge clk);
        start = 1'b0;
        lat = 1; k = 0; guard = 0;
        while (k < n && guard < 50) begin
            in_valid = 1'b1; ifmap = v_if[k]; weight = v_wt[k];
            fired = in_ready;
            @(negedge clk);
            lat++; guard++;
            if (fired) k++;
        end
        in_valid = 1'b0;
        while (!out_valid && guard < 50) begin
            @(negedge clk);
            lat++; guard++;
        end
        vectors++;
        if (guard >= 50) begin
            miscompares++;
            $display("FAIL run_job_timeout: out_valid=%0b after %0d cycles, required out_valid=1", out_valid, guard);
        end
        res = opsum;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, in_ready, out_valid} !== 3'b000 || opsum !== 32'sd0) begin
            miscompares++;
            $display("FAIL reset_state: busy/in_ready/out_valid=%b opsum=%0d, required 000 and 0", {busy, in_ready, out_valid}, opsum);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_beat();
        @(negedge clk);
        start = 1'b1; len = 16'd1; bias = 32'sd10; relu_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_cycle1: in_ready=%b busy=%b out_valid=%b, required 1 1 0", in_ready, busy, out_valid);
        end
        in_valid = 1'b1; ifmap = 8'd130; weight = -8'sd3;
        @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || opsum !== 32'sd4 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL single_cycle2: out_valid=%b opsum=%0d in_ready=%b, required 1 4 0", out_valid, opsum, in_ready);
        end
        consume();
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || opsum !== 32'sd0) begin
            miscompares++;
            $display("FAIL single_idle: out_valid=%b busy=%b opsum=%0d, required 0 0 0", out_valid, busy, opsum);
        end
    endtask

    task automatic test_multi_relu();
        logic signed [31:0] res;
        int lat;
        v_if[0] = 8'd0;   v_wt[0] = 8'sd1;
        v_if[1] = 8'd255; v_wt[1] = 8'sd1;
        v_if[2] = 8'd128; v_wt[2] = 8'sd5;
        v_if[3] = 8'd200; v_wt[3] = -8'sd2;
        run_job(4, 32'sd0, 1'b0, res, lat);
        vectors++;
        if (res !== -32'sd145 || lat != 5) begin
            miscompares++;
            $display("FAIL multi_norelu: opsum=%0d lat=%0d, required -145 lat=5", res, lat);
        end
        consume();
        run_job(4, 32'sd0, 1'b1, res, lat);
        vectors++;
        if (res !== 32'sd0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL multi_relu: opsum=%0d out_valid=%b, required 0 1", res, out_valid);
        end
        consume();
    endtask

    task automatic test_zero_len();
        logic signed [31:0] res;
        int lat;
        run_job(0, -32'sd7, 1'b0, res, lat);
        vectors++;
        if (res !== -32'sd7 || lat != 1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_len: opsum=%0d lat=%0d in_ready=%b, required -7 lat=1 0", res, lat, in_ready);
        end
        consume();
    endtask

    task automatic test_stall_backpressure();
        logic [7:0]        s_if [3];
        logic signed [7:0] s_wt [3];
        int bad;
        s_if[0] = 8'd129; s_wt[0] = 8'sd2;
        s_if[1] = 8'd127; s_wt[1] = 8'sd2;
        s_if[2] = 8'd138; s_wt[2] = 8'sd1;
        @(negedge clk);
        start = 1'b1; len = 16'd3; bias = 32'sd100; relu_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        bad = 0;
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b1; ifmap = s_if[b]; weight = s_wt[b];
            if (in_ready !== 1'b1) bad++;
            @(negedge clk);
            if (b < 2) begin
                in_valid = 1'b0; ifmap = 8'd255; weight = 8'sd127;
                repeat (2) begin
                    if (in_ready !== 1'b1 || out_valid !== 1'b0) bad++;
                    @(negedge clk);
                end
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL stall_gaps: %0d bad in_ready/out_valid samples, required 0", bad);
        end
        vectors++;
        if (out_valid !== 1'b1 || opsum !== 32'sd110) begin
            miscompares++;
            $display("FAIL stall_result: out_valid=%b opsum=%0d, required 1 110", out_valid, opsum);
        end
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            start = (c == 2);
            in_valid = 1'b1;
            @(negedge clk);
            if (out_valid !== 1'b1 || opsum !== 32'sd110 || in_ready !== 1'b0) bad++;
        end
        start = 1'b0; in_valid = 1'b0;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL backpressure_hold: %0d cycles with opsum/out_valid changed, last opsum=%0d, required 110", bad, opsum);
        end
        start = 1'b1; len = 16'd2;
        consume();
        start = 1'b0;
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL handshake_bubble: busy=%b out_valid=%b, required 0 0", busy, out_valid);
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL start_in_done_ignored: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset_mid_run();
        logic signed [31:0] res;
        int lat;
        @(negedge clk);
        start = 1'b1; len = 16'd4; bias = 32'sd50; relu_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; ifmap = 8'd200; weight = 8'sd3;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({busy, in_ready, out_valid} !== 3'b000 || opsum !== 32'sd0) begin
            miscompares++;
            $display("FAIL reset_mid_run: busy/in_ready/out_valid=%b opsum=%0d, required 000 0", {busy, in_ready, out_valid}, opsum);
        end
        v_if[0] = 8'd129; v_wt[0] = 8'sd1;
        run_job(1, 32'sd1, 1'b0, res, lat);
        vectors++;
        if (res !== 32'sd2 || lat != 2) begin
            miscompares++;
            $display("FAIL rerun_after_reset: opsum=%0d lat=%0d, required 2 lat=2", res, lat);
        end
        consume();
    endtask

    task automatic test_wrap();
        logic signed [31:0] res;
        int lat;
        v_if[0] = 8'd129; v_wt[0] = 8'sd1;
        run_job(1, 32'sd32767, 1'b0, res, lat);
        vectors++;
        if (out_valid16 !== 1'b1 || busy16 !== 1'b1 || in_ready16 !== 1'b0 || opsum16 !== -16'sd32768) begin
            miscompares++;
            $display("FAIL wrap16: out_valid=%b busy=%b in_ready=%b opsum=%0d, required 1 1 0 -32768", out_valid16, busy16, in_ready16, opsum16);
        end
        vectors++;
        if (res !== 32'sd32768) begin
            miscompares++;
            $display("FAIL wrap32_nowrap: opsum=%0d, required 32768", res);
        end
        consume();
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1; start = 1'b0; len = '0; bias = '0; relu_en = 1'b0;
        in_valid = 1'b0; ifmap = '0; weight = '0; out_ready = 1'b0;
        test_reset();
        test_single_beat();
        test_multi_relu();
        test_zero_len();
        test_stall_backpressure();
        test_reset_mid_run();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
